// File: rtl/pwm_pkg.sv
// Shared mode encoding and wave helpers for the PWM sequencer family.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package pwm_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_SAW     = 2'd0;
    localparam mode_t MODE_TRI     = 2'd1;
    localparam mode_t MODE_ONESHOT = 2'd2;
    localparam mode_t MODE_HOLD    = 2'd3;

    // Triangle fold: rises 0..cmp_max, then falls back towards 0 over the
    // second half of a 2*cmp_max period.
    function automatic logic [31:0] tri_fold(input logic [31:0] p, input logic [31:0] cmp_max);
        if (p <= cmp_max) begin
            return p;
        end
        return (cmp_max << 1) - p;
    endfunction

endpackage

// File: rtl/pwm_step_prescaler.sv
// Rate divider: emits a one-cycle step tick every STEP enabled cycles.
// Latency: tick is combinational from the counter; first tick on the first enabled cycle after reset/sync.
// Backpressure: none; i_enable low freezes the count, i_sync restarts it and suppresses that cycle's tick.
module pwm_step_prescaler #(
    parameter int STEP = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_sync,
    output logic o_tick
);

    localparam int CNT_W = (STEP > 1) ? $clog2(STEP) : 1;

    logic [CNT_W-1:0] cnt;

    // Count 0..STEP-1 while enabled; sync forces a restart from zero.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt <= '0;
        end else if (i_sync) begin
            cnt <= '0;
        end else if (i_enable) begin
            cnt <= (cnt == CNT_W'(STEP - 1)) ? '0 : cnt + 1'b1;
        end
    end

    // A sync on the same edge wins over the step, so no tick is issued.
    assign o_tick = i_enable && !i_sync && (cnt == '0);

endmodule

// File: rtl/pwm_wave_sequencer.sv
// Multi-channel PWM compare sequencer: saw/triangle/one-shot/hold ramps with per-channel phase offset.
// Latency: compare values and valid strobe are registered one edge after each step edge; sync to strobe is 2 edges.
// Backpressure: none; i_enable low freezes prescaler/phase and suppresses strobes.
module pwm_wave_sequencer
    import pwm_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = 25_000_000,
    parameter int STEP_FREQ_HZ  = 256,
    parameter int TOP_W         = 8,
    parameter int TOP           = 255,
    parameter int CMP_W         = 9,
    parameter int CHANNELS      = 3,
    parameter int PHASE_OFFSET  = 0
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic [1:0]                i_mode,
    input  logic                      i_sync,
    output logic [TOP_W-1:0]          o_top,
    output logic                      o_top_valid,
    output logic [CHANNELS*CMP_W-1:0] o_compare,
    output logic                      o_compare_valid,
    output logic                      o_done
);

    localparam int STEP    = CLOCK_FREQ_HZ / STEP_FREQ_HZ;
    localparam int CMP_MAX = TOP + 1;
    // Phase spans 0..2*CMP_MAX-1; sums with an offset need one more bit.
    localparam int PH_W    = CMP_W + 1;
    localparam int SW      = CMP_W + 2;

    localparam logic [SW-1:0] P_SAW     = SW'(CMP_MAX + 1);
    localparam logic [SW-1:0] P_TRI     = SW'(2 * CMP_MAX);
    localparam logic [SW-1:0] CMP_MAX_S = SW'(CMP_MAX);

    logic                      step_tick;
    logic [PH_W-1:0]           phase_q;
    logic [PH_W-1:0]           phase_d;
    mode_t                     mode_q;
    logic [CHANNELS*CMP_W-1:0] cmp_q;
    logic [CHANNELS*CMP_W-1:0] cmp_d;
    logic                      vld_q;
    logic                      done_q;
    logic                      done_d;
    logic                      mode_chg;
    logic [SW-1:0]             eff_phase;
    logic [SW-1:0]             ph_inc;
    logic [SW-1:0]             period;

    pwm_step_prescaler #(
        .STEP (STEP)
    ) u_prescaler (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_sync   (i_sync),
        .o_tick   (step_tick)
    );

    // Shared step arithmetic: a mode change restarts the ramp at phase 0.
    always_comb begin
        mode_chg  = (i_mode != mode_q);
        eff_phase = mode_chg ? '0 : SW'(phase_q);
        ph_inc    = eff_phase + 1'b1;
        period    = (i_mode == MODE_TRI) ? P_TRI : P_SAW;
        phase_d   = phase_q;
        done_d    = done_q;
        case (i_mode)
            MODE_SAW, MODE_TRI: begin
                phase_d = (ph_inc >= period) ? '0 : PH_W'(ph_inc);
            end
            MODE_ONESHOT: begin
                phase_d = (eff_phase >= CMP_MAX_S) ? PH_W'(CMP_MAX_S) : PH_W'(ph_inc);
                if (eff_phase == CMP_MAX_S) begin
                    done_d = 1'b1;
                end
            end
            default: begin
                phase_d = mode_chg ? PH_W'(1) : phase_q;
            end
        endcase
        if (mode_chg) begin
            done_d = 1'b0;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        localparam logic [SW-1:0] OFS = SW'(k * PHASE_OFFSET);

        logic [SW-1:0]    sum;
        logic [SW-1:0]    phk;
        logic [CMP_W-1:0] wave;

        // Offset phase wrapped into one period, then shaped per mode.
        always_comb begin
            sum = eff_phase + OFS;
            phk = (sum >= period) ? sum - period : sum;
            case (i_mode)
                MODE_TRI:     wave = CMP_W'(tri_fold(32'(phk), 32'(CMP_MAX)));
                MODE_ONESHOT: wave = CMP_W'(eff_phase);
                MODE_HOLD:    wave = mode_chg ? CMP_W'(phk) : cmp_q[k*CMP_W +: CMP_W];
                default:      wave = CMP_W'(phk);
            endcase
        end

        assign cmp_d[k*CMP_W +: CMP_W] = wave;
    end

    // Sequencer state; strobe follows the step tick by one edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            phase_q <= '0;
            mode_q  <= MODE_SAW;
            cmp_q   <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            vld_q <= step_tick;
            if (i_sync) begin
                phase_q <= '0;
                done_q  <= 1'b0;
            end else if (step_tick) begin
                phase_q <= phase_d;
                mode_q  <= i_mode;
                cmp_q   <= cmp_d;
                done_q  <= done_d;
            end
        end
    end

    assign o_top           = TOP_W'(TOP);
    assign o_top_valid     = vld_q;
    assign o_compare       = cmp_q;
    assign o_compare_valid = vld_q;
    assign o_done          = done_q;

endmodule

// File: tb/tb_pwm_wave_sequencer.sv
// Directed bench for pwm_wave_sequencer with STEP=4, CMP_MAX=4, two channels, offset 2.
// Latency: strobes expected at cycle 1 + 4*n after reset release.
// Backpressure: n/a.
module tb_pwm_wave_sequencer;

    localparam logic [1:0] M_SAW = 2'd0;
    localparam logic [1:0] M_TRI = 2'd1;
    localparam logic [1:0] M_ONE = 2'd2;
    localparam logic [1:0] M_HLD = 2'd3;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_enable = 1'b1;
    logic [1:0] i_mode = 2'd0;
    logic       i_sync = 1'b0;
    logic [1:0] o_top;
    logic       o_top_valid;
    logic [5:0] o_compare;
    logic       o_compare_valid;
    logic       o_done;

    pwm_wave_sequencer #(
        .CLOCK_FREQ_HZ (40),
        .STEP_FREQ_HZ  (10),
        .TOP_W         (2),
        .TOP           (3),
        .CMP_W         (3),
        .CHANNELS      (2),
        .PHASE_OFFSET  (2)
    ) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_enable        (i_enable),
        .i_mode          (i_mode),
        .i_sync          (i_sync),
        .o_top           (o_top),
        .o_top_valid     (o_top_valid),
        .o_compare       (o_compare),
        .o_compare_valid (o_compare_valid),
        .o_done          (o_done)
    );

    always #5 i_clk = ~i_clk;

    int edge_cnt = 0;
    int base     = 0;
    int tests    = 0;
    int fails    = 0;

    always @(posedge i_clk) edge_cnt++;

    typedef struct {
        logic [1:0] mode;
        int         ch0;
        int         ch1;
        int         done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] m, input int c0, input int c1, input int d);
        vec_t v;
        v.mode = m;
        v.ch0  = c0;
        v.ch1  = c1;
        v.done = d;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [1:0] m);
        @(negedge i_clk);
        i_reset  = 1'b1;
        i_mode   = m;
        i_sync   = 1'b0;
        i_enable = 1'b1;
        @(negedge i_clk);
        chk("rst_cmp", int'(o_compare), 0);
        chk("rst_vld", int'(o_compare_valid), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_top", int'(o_top), 3);
        i_reset = 1'b0;
        base    = edge_cnt;
    endtask

    // Waits (bounded) for the next strobe, sampling on falling edges.
    task automatic wait_strobe(input string name, output int cyc);
        cyc = -1;
        for (int n = 0; n < 24; n++) begin
            @(negedge i_clk);
            if (o_compare_valid) begin
                cyc = edge_cnt - base;
                return;
            end
        end
        chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic chk_strobe(input string name, input int cyc_exp, input int c0, input int c1, input int d);
        int cyc;
        wait_strobe(name, cyc);
        if (cyc_exp >= 0) chk({name, "_cycle"}, cyc, cyc_exp);
        chk({name, "_ch0"}, int'(o_compare[2:0]), c0);
        chk({name, "_ch1"}, int'(o_compare[5:3]), c1);
        chk({name, "_done"}, int'(o_done), d);
        chk({name, "_topv"}, int'(o_top_valid), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int cnt;

        // SAW from reset
        add(M_SAW, 0, 2, 0); add(M_SAW, 1, 3, 0); add(M_SAW, 2, 4, 0); add(M_SAW, 3, 0, 0);
        add(M_SAW, 4, 1, 0); add(M_SAW, 0, 2, 0); add(M_SAW, 1, 3, 0);
        // TRI from reset
        add(M_TRI, 0, 2, 0); add(M_TRI, 1, 3, 0); add(M_TRI, 2, 4, 0); add(M_TRI, 3, 3, 0);
        add(M_TRI, 4, 2, 0); add(M_TRI, 3, 1, 0); add(M_TRI, 2, 0, 0); add(M_TRI, 1, 1, 0);
        add(M_TRI, 0, 2, 0); add(M_TRI, 1, 3, 0);
        // ONESHOT from reset
        add(M_ONE, 0, 0, 0); add(M_ONE, 1, 1, 0); add(M_ONE, 2, 2, 0); add(M_ONE, 3, 3, 0);
        add(M_ONE, 4, 4, 1); add(M_ONE, 4, 4, 1); add(M_ONE, 4, 4, 1);

        idx = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 0 || vecs[i].mode != vecs[i-1].mode) begin
                do_reset(vecs[i].mode);
                idx = 0;
            end
            chk(vecs[i].mode == M_SAW ? "saw_top" : "wave_top", int'(o_top), 3);
            chk_strobe($sformatf("vec%0d", i), 1 + 4 * idx, vecs[i].ch0, vecs[i].ch1, vecs[i].done);
            idx++;
        end

        // ONESHOT restart via sync: done clears, ramp restarts at 0.
        @(negedge i_clk);
        i_sync = 1'b1;
        @(negedge i_clk);
        i_sync = 1'b0;
        chk("sync_vld_low", int'(o_compare_valid), 0);
        chk("sync_done_clr", int'(o_done), 0);
        @(negedge i_clk);
        chk("sync_vld", int'(o_compare_valid), 1);
        chk("sync_ch0", int'(o_compare[2:0]), 0);
        chk("sync_ch1", int'(o_compare[5:3]), 0);
        for (int v = 1; v <= 4; v++) begin
            chk_strobe($sformatf("one_re%0d", v), -1, v, v, (v == 4) ? 1 : 0);
        end

        // Asynchronous reset between edges clears outputs immediately.
        #2;
        i_reset = 1'b1;
        #1;
        chk("arst_cmp", int'(o_compare), 0);
        chk("arst_vld", int'(o_compare_valid), 0);
        chk("arst_done", int'(o_done), 0);
        chk("arst_top", int'(o_top), 3);
        @(negedge i_clk);
        i_reset = 1'b0;
        i_mode  = M_SAW;
        base    = edge_cnt;
        chk_strobe("arst_first", 1, 0, 2, 0);

        // SAW -> HOLD: restart at 0, then frozen values with continuing strobes.
        chk_strobe("hold_pre1", 5, 1, 3, 0);
        chk_strobe("hold_pre2", 9, 2, 4, 0);
        i_mode = M_HLD;
        chk_strobe("hold_chg", 13, 0, 2, 0);
        chk_strobe("hold_a", 17, 0, 2, 0);
        chk_strobe("hold_b", 21, 0, 2, 0);

        // Back to SAW, then pause with enable low for 7 cycles.
        i_mode = M_SAW;
        chk_strobe("en_chg", 25, 0, 2, 0);
        chk_strobe("en_pre", 29, 1, 3, 0);
        @(negedge i_clk);
        i_enable = 1'b0;
        cnt = 0;
        for (int n = 0; n < 7; n++) begin
            @(negedge i_clk);
            if (o_compare_valid) cnt++;
        end
        chk("en_off_strobes", cnt, 0);
        i_enable = 1'b1;
        chk_strobe("en_resume", 40, 2, 4, 0);
        chk_strobe("en_next", 44, 3, 0, 0);

        // Sync coincident with a step edge: no strobe, then phase-0 strobe.
        repeat (3) @(negedge i_clk);
        i_sync = 1'b1;
        @(negedge i_clk);
        i_sync = 1'b0;
        chk("sync_step_vld", int'(o_compare_valid), 0);
        @(negedge i_clk);
        chk("sync_step_vld2", int'(o_compare_valid), 1);
        chk("sync_step_ch0", int'(o_compare[2:0]), 0);
        chk("sync_step_ch1", int'(o_compare[5:3]), 2);
        chk_strobe("sync_after", 53, 1, 3, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
